// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one fixed-latency single-ported memory between the fetch
//            and data ports, data first with a streak limit against starvation.
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int XLEN            = 32,
    parameter int MEM_LAT         = 2,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    input  logic            if_flush,
    output logic            if_ready,
    output logic [XLEN-1:0] if_rdata,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [XLEN-1:0] dm_addr,
    input  logic [XLEN-1:0] dm_wdata,
    input  logic [3:0]      dm_wstrb,
    output logic            dm_ready,
    output logic [XLEN-1:0] dm_rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            busy
);

    localparam int                    c_streak_w   = $clog2(MAX_DATA_STREAK + 2);
    localparam logic [c_streak_w-1:0] c_streak_max = c_streak_w'(MAX_DATA_STREAK);
    localparam logic [c_streak_w-1:0] c_streak_one = c_streak_w'(1);
    localparam logic [3:0]            c_cnt_init   = 4'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [c_streak_w-1:0] r_streak;
    logic                  r_grant_if;
    logic                  r_if_flushed;
    logic                  w_grant_if;
    logic                  w_flush_hit;

    // Fetch wins only when data is absent or has used up its streak allowance.
    assign w_grant_if  = if_req & (~dm_req | (r_streak == c_streak_max));
    assign w_flush_hit = r_grant_if & if_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_streak     <= '0;
            r_grant_if   <= 1'b0;
            r_if_flushed <= 1'b0;
            if_ready     <= 1'b0;
            if_rdata     <= '0;
            dm_ready     <= 1'b0;
            dm_rdata     <= '0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wstrb    <= '0;
            busy         <= 1'b0;
        end else begin
            mem_en   <= 1'b0;
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (if_req || dm_req) begin
                        r_grant_if <= w_grant_if;
                        mem_en     <= 1'b1;
                        busy       <= 1'b1;
                        r_state    <= ST_ISSUE;
                        if (w_grant_if) begin
                            mem_addr  <= if_addr;
                            mem_we    <= 1'b0;
                            mem_wdata <= '0;
                            mem_wstrb <= 4'h0;
                            r_streak  <= '0;
                        end else begin
                            mem_addr  <= dm_addr;
                            mem_we    <= dm_we;
                            mem_wdata <= dm_wdata;
                            mem_wstrb <= dm_wstrb;
                            r_streak  <= if_req ? (r_streak + c_streak_one) : '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (w_flush_hit) begin
                        r_if_flushed <= 1'b1;
                    end
                    r_cnt   <= c_cnt_init;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_flush_hit) begin
                        r_if_flushed <= 1'b1;
                    end
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        // A flush seen on this last wait cycle must also suppress the pulse.
                        if (r_grant_if) begin
                            if_rdata <= mem_rdata;
                            if_ready <= ~(r_if_flushed | if_flush);
                        end else begin
                            if (!mem_we) begin
                                dm_rdata <= mem_rdata;
                            end
                            dm_ready <= 1'b1;
                        end
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_if_flushed <= 1'b0;
                    busy         <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed and randomized bench for mem_arbiter against a
//            transaction-level schedule model.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

    localparam int XLEN = 32;
    localparam int L    = 2;
    localparam int MS   = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_req, if_flush, if_ready;
    logic [XLEN-1:0] if_addr, if_rdata;
    logic            dm_req, dm_we, dm_ready;
    logic [XLEN-1:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]      dm_wstrb, mem_wstrb;
    logic            mem_en, mem_we, busy;
    logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.XLEN(XLEN), .MEM_LAT(L), .MAX_DATA_STREAK(MS)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_ready(if_ready), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_wstrb(dm_wstrb), .dm_ready(dm_ready), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .busy(busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Environment memory (serves the DUT) and the model's own copy.
    logic [31:0] env_mem [256];
    logic [31:0] ref_mem [256];
    int          en_cyc  = -100;
    logic [31:0] en_data = '0;

    // Model: one access at a time, described by its grant cycle and attributes.
    bit          m_valid = 0, m_gif = 0, m_we = 0, m_flushed = 0;
    int          m_s = -100, m_free = 0, m_streak = 0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_data = '0;
    logic [3:0]  m_wstrb = '0;
    logic [31:0] m_if_rdata = '0, m_dm_rdata = '0;

    bit seen_if = 0, seen_dm = 0, hold_if = 0, hold_dm = 0;
    bit if_dropped = 0, dm_dropped = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rand_addr();
        return $urandom() & 32'hFFFF_FFFC;
    endfunction

    task automatic check_outputs();
        bit act, e_en, e_busy, e_ifr, e_dmr;
        int done;
        act    = m_valid && (cyc > m_s);
        done   = m_s + 2 + L;
        e_en   = act && (cyc == m_s + 1);
        e_busy = act && (cyc <= done);
        e_ifr  = act && m_gif && (cyc == done) && !m_flushed;
        e_dmr  = act && !m_gif && (cyc == done);
        chk_eq("mem_en", 32'(mem_en), 32'(e_en));
        chk_eq("busy", 32'(busy), 32'(e_busy));
        chk_eq("if_ready", 32'(if_ready), 32'(e_ifr));
        chk_eq("dm_ready", 32'(dm_ready), 32'(e_dmr));
        chk_eq("if_rdata", if_rdata, m_if_rdata);
        chk_eq("dm_rdata", dm_rdata, m_dm_rdata);
        if (e_en && mem_en) begin
            chk_eq("mem_addr", mem_addr, m_addr);
            chk_eq("mem_we", 32'(mem_we), 32'(m_we));
            chk_eq("mem_wstrb", 32'(mem_wstrb), 32'(m_wstrb));
            if (m_we) chk_eq("mem_wdata", mem_wdata, m_wdata);
        end
    endtask

    task automatic model_update();
        int idx;
        bit gif;
        if (rst) begin
            m_valid = 0; m_flushed = 0; m_streak = 0;
            m_if_rdata = '0; m_dm_rdata = '0;
            m_free = cyc + 1;
            return;
        end
        if (m_valid && m_gif && if_flush && cyc >= m_s + 1 && cyc <= m_s + 1 + L) m_flushed = 1;
        if (m_valid && cyc == m_s + 1 + L) begin
            if (m_gif) m_if_rdata = m_data;
            else if (!m_we) m_dm_rdata = m_data;
        end
        if (cyc >= m_free && (if_req || dm_req)) begin
            gif = if_req && (!dm_req || m_streak == MS);
            m_s = cyc; m_valid = 1; m_flushed = 0; m_gif = gif;
            m_free = cyc + L + 3;
            if (gif) begin
                m_addr = if_addr; m_we = 0; m_wstrb = '0; m_wdata = '0; m_streak = 0;
            end else begin
                m_addr = dm_addr; m_we = dm_we; m_wdata = dm_wdata; m_wstrb = dm_wstrb;
                m_streak = if_req ? m_streak + 1 : 0;
            end
            idx    = int'(m_addr[9:2]);
            m_data = ref_mem[idx];
            if (m_we) ref_mem[idx] = merge(ref_mem[idx], m_wdata, m_wstrb);
        end
    endtask

    // One clock cycle: check mid-cycle, advance the model, then drive the next cycle.
    task automatic step();
        int idx;
        @(negedge clk);
        check_outputs();
        seen_if = if_ready;
        seen_dm = dm_ready;
        if (mem_en) begin
            idx     = int'(mem_addr[9:2]);
            en_cyc  = cyc;
            en_data = env_mem[idx];
            if (mem_we) env_mem[idx] = merge(env_mem[idx], mem_wdata, mem_wstrb);
        end
        model_update();
        @(posedge clk);
        #1;
        cyc++;
        mem_rdata  = (cyc == en_cyc + L) ? en_data : $urandom();
        if_dropped = 0;
        dm_dropped = 0;
        if (seen_if) begin
            if (hold_if) if_addr = rand_addr();
            else begin if_req = 0; if_dropped = 1; end
        end
        if (seen_dm) begin
            if (hold_dm) begin
                dm_addr = rand_addr(); dm_we = 1'($urandom());
                dm_wdata = $urandom(); dm_wstrb = 4'($urandom());
            end else begin
                dm_req = 0; dm_dropped = 1;
            end
        end
    endtask

    task automatic wait_ready(input bit want_if, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget && at < 0; i++) begin
            step();
            if (want_if ? seen_if : seen_dm) at = cyc - 1;
        end
        if (at < 0) chk_eq(want_if ? "timeout_if" : "timeout_dm", 32'd0, 32'd1);
    endtask

    initial begin
        int t0, t_if, t_dm, sat_dm, sat_if;
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = 32'(i) * 32'h9E37_79B1 + 32'h1234;
            ref_mem[i] = env_mem[i];
        end
        env_mem[64]  = 32'h0050_0093; ref_mem[64]  = 32'h0050_0093;
        env_mem[128] = 32'h0000_0013; ref_mem[128] = 32'h0000_0013;

        rst = 1; if_req = 0; if_addr = '0; if_flush = 0;
        dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        step();
        chk_eq("rst_mem_addr", mem_addr, 32'h0);
        chk_eq("rst_mem_wdata", mem_wdata, 32'h0);
        chk_eq("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
        chk_eq("rst_mem_we", 32'(mem_we), 32'h0);
        rst = 0;
        step();

        // Lone fetch: ready MEM_LAT+2 cycles after the request.
        t0 = cyc; if_req = 1; if_addr = 32'h100;
        wait_ready(1, 20, t_if);
        chk_eq("fetch_latency", 32'(t_if - t0), 32'(L + 2));
        chk_eq("fetch_data", if_rdata, 32'h0050_0093);

        // Simultaneous: data first, fetch follows.
        t0 = cyc; if_req = 1; if_addr = 32'h104; dm_req = 1; dm_we = 0; dm_addr = 32'h2000;
        wait_ready(0, 20, t_dm);
        wait_ready(1, 20, t_if);
        chk_eq("simul_dm_latency", 32'(t_dm - t0), 32'(L + 2));
        chk_eq("simul_if_latency", 32'(t_if - t0), 32'(2 * L + 5));

        // Store, then load it back.
        dm_req = 1; dm_we = 1; dm_addr = 32'h2004; dm_wdata = 32'hDEAD_BEEF; dm_wstrb = 4'hF;
        wait_ready(0, 20, t_dm);
        dm_req = 1; dm_we = 0; dm_addr = 32'h2004;
        wait_ready(0, 20, t_dm);
        chk_eq("load_after_store", dm_rdata, 32'hDEAD_BEEF);

        // Flush on the first WAIT cycle; the redirected fetch completes normally.
        t0 = cyc; if_req = 1; if_addr = 32'h300;
        step(); step();
        if_flush = 1; if_addr = 32'h200;
        step();
        if_flush = 0;
        wait_ready(1, 20, t_if);
        chk_eq("flush_refetch_latency", 32'(t_if - t0), 32'(L + 7));
        chk_eq("flush_refetch_data", if_rdata, 32'h0000_0013);

        // Reset in the middle of a load.
        step();
        dm_req = 1; dm_we = 0; dm_addr = 32'h40;
        step(); step();
        rst = 1;
        step();
        rst = 0; dm_req = 0;
        repeat (8) step();

        // Both requesters saturated: MS data grants between consecutive fetches.
        hold_if = 1; hold_dm = 1;
        if_req = 1; if_addr = rand_addr();
        dm_req = 1; dm_we = 0; dm_addr = rand_addr(); dm_wstrb = 4'hF;
        sat_dm = 0; sat_if = 0;
        for (int i = 0; i < 160; i++) begin
            step();
            if (seen_dm) sat_dm++;
            if (seen_if) begin
                if (sat_if > 0) chk_eq("streak_len", 32'(sat_dm), 32'(MS));
                sat_if++;
                sat_dm = 0;
            end
        end
        if (sat_if < 3) chk_eq("streak_fetches", 32'(sat_if), 32'd3);
        hold_if = 0; hold_dm = 0;

        // Randomized traffic with occasional flushes and resets.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (!if_req && !if_dropped && $urandom_range(0, 1) == 1) begin
                if_req = 1; if_addr = rand_addr();
            end
            if_flush = if_req && ($urandom_range(0, 7) == 0);
            if (if_flush) if_addr = rand_addr();
            if (!dm_req && !dm_dropped && $urandom_range(0, 1) == 1) begin
                dm_req = 1; dm_we = 1'($urandom()); dm_addr = rand_addr();
                dm_wdata = $urandom(); dm_wstrb = 4'($urandom());
            end
            step();
        end
        rst = 0; if_flush = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
